// File: rtl/sobel_stream_core.sv
// sobel_stream_core
//
// Streaming 3x3 Sobel edge-magnitude core. Greyscale pixels arrive one per AXI-Stream
// beat. Each TLAST-terminated packet is one image line. Two circular line buffers hold
// the two previous rows. Every accepted input beat produces exactly one output beat,
// three cycles later when there is no backpressure. The output beat carries the edge
// magnitude of the 3x3 window that ends at that pixel. Border positions output 0.
//
// Parameters
//   DATAWIDTH  AXIS TDATA width (a multiple of PIX_W)
//   PIX_W      pixel width; the input pixel is S_AXIS_TDATA[PIX_W-1:0]
//   ADDRWIDTH  line-buffer address width; maximum line length is 2**ADDRWIDTH
//   SHIFT      right shift applied to |Gx|+|Gy| before saturation
//
// Ports
//   CLK, RESET      clock; synchronous active-high reset
//   S_AXIS_*        pixel input (TDATA, TUSER = start of frame, TLAST = end of line,
//                   TVALID, TREADY)
//   M_AXIS_*        magnitude output, replicated into every PIX_W lane
//                   (TDATA, TLAST, TVALID, TREADY)
//   THRESH          binarisation threshold (only present with SOBEL_THRESH_EN)
//   OVERFLOW        sticky flag: a line exceeded 2**ADDRWIDTH pixels
//
// Build option
//   SOBEL_THRESH_EN  When defined, each non-border output lane becomes all-ones if the
//                    magnitude is >= THRESH, and 0 otherwise.

module sobel_stream_core #(
  parameter int DATAWIDTH = 32,
  parameter int PIX_W     = 8,
  parameter int ADDRWIDTH = 6,
  parameter int SHIFT     = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [DATAWIDTH-1:0] S_AXIS_TDATA,
  input  logic                 S_AXIS_TUSER,
  input  logic                 S_AXIS_TLAST,
  input  logic                 S_AXIS_TVALID,
  output logic                 S_AXIS_TREADY,
  output logic [DATAWIDTH-1:0] M_AXIS_TDATA,
  output logic                 M_AXIS_TLAST,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
`ifdef SOBEL_THRESH_EN
  input  logic [PIX_W-1:0]     THRESH,
`endif
  output logic                 OVERFLOW
);

  localparam int LMAX  = 2 ** ADDRWIDTH;
  localparam int LANES = DATAWIDTH / PIX_W;
  localparam int GW    = PIX_W + 3;

  function automatic logic signed [GW-1:0] widen(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic [GW-1:0] abs_g(input logic signed [GW-1:0] g);
    return (g < 0) ? $unsigned(-g) : $unsigned(g);
  endfunction

  function automatic logic [PIX_W-1:0] shift_sat(input logic [GW:0] sum);
    logic [GW:0] sh;
    sh = sum >> SHIFT;
    return (|sh[GW:PIX_W]) ? {PIX_W{1'b1}} : sh[PIX_W-1:0];
  endfunction

  // Single global enable: the whole pipeline moves whenever the output slot can take data.
  logic adv, accept;
  assign adv           = !M_AXIS_TVALID | M_AXIS_TREADY;
  assign S_AXIS_TREADY = adv & !RESET;
  assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;

  logic [PIX_W-1:0] pix;
  logic             unused_upper;
  assign pix          = S_AXIS_TDATA[PIX_W-1:0];
  assign unused_upper = ^S_AXIS_TDATA[DATAWIDTH-1:PIX_W];

  // Line buffers. When sel is 0, lb_a holds row r-1 and lb_b holds row r-2.
  // The incoming pixel overwrites the r-2 entry after that entry has been read.
  logic [PIX_W-1:0]     lb_a [LMAX];
  logic [PIX_W-1:0]     lb_b [LMAX];
  logic                 sel;
  logic [ADDRWIDTH-1:0] col;
  logic                 wrapped;   // the current line has already passed LMAX pixels
  logic [1:0]           rowcnt;
  logic [1:0]           eff_row;
  logic [PIX_W-1:0]     rd_up1, rd_up2;
  logic                 overflow_q;

  assign eff_row = S_AXIS_TUSER ? 2'd0 : rowcnt;
  assign rd_up1  = sel ? lb_b[col] : lb_a[col];
  assign rd_up2  = sel ? lb_a[col] : lb_b[col];
  assign OVERFLOW = overflow_q;

  always_ff @(posedge CLK) begin
    if (accept) begin
      if (sel) lb_a[col] <= pix;
      else     lb_b[col] <= pix;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      col        <= '0;
      wrapped    <= 1'b0;
      rowcnt     <= 2'd0;
      sel        <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      if (wrapped) overflow_q <= 1'b1;
      if (S_AXIS_TLAST) begin
        col     <= '0;
        wrapped <= 1'b0;
        rowcnt  <= (eff_row == 2'd2) ? 2'd2 : eff_row + 2'd1;
        sel     <= ~sel;
      end else begin
        col    <= col + ADDRWIDTH'(1);
        rowcnt <= eff_row;
        if (&col) wrapped <= 1'b1;
      end
    end
  end

  // ---- stage 0: line-buffer read and window shift ----
  // Tap [0] holds column c, [1] holds c-1 and [2] holds c-2. The taps shift only on
  // accepted beats, so they carry over pipeline bubbles.
  logic [PIX_W-1:0] w_cur_p0 [3];
  logic [PIX_W-1:0] w_up1_p0 [3];
  logic [PIX_W-1:0] w_up2_p0 [3];
  logic             vld_p0, last_p0, border_p0;

  always_ff @(posedge CLK) begin
    if (RESET)    vld_p0 <= 1'b0;
    else if (adv) vld_p0 <= accept;
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      w_cur_p0[2] <= w_cur_p0[1];
      w_cur_p0[1] <= w_cur_p0[0];
      w_cur_p0[0] <= pix;
      w_up1_p0[2] <= w_up1_p0[1];
      w_up1_p0[1] <= w_up1_p0[0];
      w_up1_p0[0] <= rd_up1;
      w_up2_p0[2] <= w_up2_p0[1];
      w_up2_p0[1] <= w_up2_p0[0];
      w_up2_p0[0] <= rd_up2;
      last_p0     <= S_AXIS_TLAST;
      border_p0   <= (eff_row < 2'd2) | (!wrapped & (col < ADDRWIDTH'(2)));
    end
  end

  // ---- stage 1: Gx / Gy ----
  logic signed [GW-1:0] gx_c, gy_c;
  logic signed [GW-1:0] gx_p1, gy_p1;
  logic                 vld_p1, last_p1, border_p1;

  always_comb begin
    gx_c = (widen(w_up2_p0[0]) - widen(w_up2_p0[2]))
         + ((widen(w_up1_p0[0]) - widen(w_up1_p0[2])) <<< 1)
         + (widen(w_cur_p0[0]) - widen(w_cur_p0[2]));
    gy_c = (widen(w_cur_p0[2]) - widen(w_up2_p0[2]))
         + ((widen(w_cur_p0[1]) - widen(w_up2_p0[1])) <<< 1)
         + (widen(w_cur_p0[0]) - widen(w_up2_p0[0]));
  end

  always_ff @(posedge CLK) begin
    if (RESET)    vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= vld_p0;
  end

  always_ff @(posedge CLK) begin
    if (adv) begin
      gx_p1     <= gx_c;
      gy_p1     <= gy_c;
      last_p1   <= last_p0;
      border_p1 <= border_p0;
    end
  end

  // ---- stage 2: magnitude, saturation, output register ----
  logic [GW:0]          sum_c;
  logic [PIX_W-1:0]     mag_c, lane_c;
  logic [DATAWIDTH-1:0] data_p2;
  logic                 vld_p2, last_p2;

  always_comb begin
    sum_c = {1'b0, abs_g(gx_p1)} + {1'b0, abs_g(gy_p1)};
    mag_c = shift_sat(sum_c);
`ifdef SOBEL_THRESH_EN
    lane_c = (mag_c >= THRESH) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
    lane_c = mag_c;
`endif
    if (border_p1) lane_c = '0;
  end

  // The output register is cleared on reset so that every output reads 0 in reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      data_p2 <= '0;
    end else if (adv) begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      data_p2 <= {LANES{lane_c}};
    end
  end

  assign M_AXIS_TDATA  = data_p2;
  assign M_AXIS_TLAST  = last_p2;
  assign M_AXIS_TVALID = vld_p2;

endmodule

// File: tb/tb_sobel_stream_core.sv
// Testbench for sobel_stream_core (default parameters: 32-bit TDATA, 8-bit pixels,
// 64-pixel lines, SHIFT 2). A row-array reference model predicts every output beat.
// Directed scenarios and a randomized multi-frame run drive the design.
module tb_sobel_stream_core;
  localparam int LM = 64;
  localparam int SH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic        s_tuser, s_tlast, s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic        m_tlast, m_tvalid;
  logic        m_tready = 1'b1;
  logic        overflow;
`ifdef SOBEL_THRESH_EN
  logic [7:0]  thresh;
`endif

  always #5 clk = ~clk;

  sobel_stream_core dut (
    .CLK(clk), .RESET(rst),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TUSER(s_tuser), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TLAST(m_tlast), .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TREADY(m_tready),
`ifdef SOBEL_THRESH_EN
    .THRESH(thresh),
`endif
    .OVERFLOW(overflow)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the previous two rows and the current row as plain arrays.
  int m_row = 0, m_col = 0;
  int p1 [LM];
  int p2 [LM];
  int pc [LM];
  logic [32:0] exp_q [$];
  int          stamp_q [$];
  logic [31:0] out_data [4096];
  logic        out_last [4096];
  int          out_n = 0;
  bit          lat_chk = 0;

  function automatic logic [31:0] model_beat(input int pix, input bit user, input bit last);
    int eff, c, a0, a1, a2, gx, gy, mag, lane;
    logic [7:0] l8;
    eff = user ? 0 : m_row;
    c = m_col;
    a0 = c % LM; a1 = (c + LM - 1) % LM; a2 = (c + LM - 2) % LM;
    pc[a0] = pix;
    lane = 0;
    if (eff >= 2 && c >= 2) begin
      gx = (p2[a0] - p2[a2]) + 2 * (p1[a0] - p1[a2]) + (pc[a0] - pc[a2]);
      gy = (pc[a2] + 2 * pc[a1] + pc[a0]) - (p2[a2] + 2 * p2[a1] + p2[a0]);
      mag = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / (1 << SH);
      if (mag > 255) mag = 255;
`ifdef SOBEL_THRESH_EN
      lane = (mag >= int'(thresh)) ? 255 : 0;
`else
      lane = mag;
`endif
    end
    if (last) begin
      p2 = p1; p1 = pc;
      m_row = (eff + 1 > 2) ? 2 : eff + 1;
      m_col = 0;
    end else begin
      m_col = c + 1;
      m_row = eff;
    end
    l8 = lane[7:0];
    return {4{l8}};
  endfunction

  // Compare process: checks every output transfer and the ready relation on every cycle.
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    int st;
    if (rst) begin
      exp_q.delete();
      stamp_q.delete();
      m_row = 0;
      m_col = 0;
    end else begin
      check("s_tready", {63'd0, s_tready}, {63'd0, (!m_tvalid || m_tready)});
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          st = stamp_q.pop_front();
          check("m_tdata", {32'd0, m_tdata}, {32'd0, e[31:0]});
          check("m_tlast", {63'd0, m_tlast}, {63'd0, e[32]});
          if (lat_chk) check("latency", 64'(cyc - st), 64'd3);
        end
        if (out_n < 4096) begin
          out_data[out_n] = m_tdata;
          out_last[out_n] = m_tlast;
          out_n++;
        end
      end
      if (s_tvalid && s_tready) begin
        exp_q.push_back({s_tlast, model_beat(int'(s_tdata[7:0]), s_tuser, s_tlast)});
        stamp_q.push_back(cyc);
      end
    end
  end

  // Output-ready driver: an optional random pattern plus a forced 5-cycle stall window.
  bit rnd_rdy = 0;
  int stall_at = -100;
  always @(posedge clk) begin
    #2;
    m_tready = !(cyc >= stall_at && cyc < stall_at + 5) &&
               (!rnd_rdy || ($urandom_range(0, 3) != 0));
  end

  task automatic send(input logic [7:0] pix, input bit user, input bit last);
    int w;
    logic [23:0] up;
    up = 24'($urandom());
    s_tdata = {up, pix};
    s_tuser = user; s_tlast = last; s_tvalid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!s_tready && w < 2000) begin @(negedge clk); w++; end
    if (!s_tready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_line(input int len, input logic [7:0] lo, input logic [7:0] hi, input bit user);
    for (int c = 0; c < len; c++) send((c < len / 2) ? lo : hi, user && c == 0, c == len - 1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin @(posedge clk); w++; end
    #1;
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic or_all(input string name, input int base, input int n);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) acc |= out_data[base + i];
    check(name, {32'd0, acc}, 64'd0);
  endtask

  task automatic check_split4(input string tag, input int base);
    check({tag, "_count"}, 64'(out_n - base), 64'd128);
    check({tag, "_r2c16"}, {32'd0, out_data[base + 80]}, 64'hFFFF_FFFF);
    check({tag, "_r2c17"}, {32'd0, out_data[base + 81]}, 64'hFFFF_FFFF);
    check({tag, "_r3c16"}, {32'd0, out_data[base + 112]}, 64'hFFFF_FFFF);
    check({tag, "_r3c17"}, {32'd0, out_data[base + 113]}, 64'hFFFF_FFFF);
    check({tag, "_r2c18"}, {32'd0, out_data[base + 82]}, 64'd0);
    check({tag, "_r2c15"}, {32'd0, out_data[base + 79]}, 64'd0);
    check({tag, "_r1c16"}, {32'd0, out_data[base + 48]}, 64'd0);
    check({tag, "_r0c17"}, {32'd0, out_data[base + 17]}, 64'd0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, len, nl;
    rst = 1'b1; s_tdata = '0; s_tuser = 0; s_tlast = 0; s_tvalid = 0;
`ifdef SOBEL_THRESH_EN
    thresh = 8'h01;
`endif
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_tvalid", {63'd0, m_tvalid}, 64'd0);
    check("reset_tdata", {32'd0, m_tdata}, 64'd0);
    check("reset_tlast", {63'd0, m_tlast}, 64'd0);
    check("reset_overflow", {63'd0, overflow}, 64'd0);
    check("reset_s_tready", {63'd0, s_tready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two zero lines, latency checked on every beat.
    lat_chk = 1;
    base = out_n;
    send_line(32, 8'h00, 8'h00, 1'b1);
    send_line(32, 8'h00, 8'h00, 1'b0);
    drain();
    lat_chk = 0;
    check("t1_count", 64'(out_n - base), 64'd64);
    check("t1_last32", {63'd0, out_last[base + 31]}, 64'd1);
    check("t1_last64", {63'd0, out_last[base + 63]}, 64'd1);
    check("t1_nolast31", {63'd0, out_last[base + 30]}, 64'd0);
    or_all("t1_zero", base, 64);

    // Step edge at column 16.
    base = out_n;
    for (int l = 0; l < 4; l++) send_line(32, 8'h00, 8'hFF, l == 0);
    drain();
    check_split4("t2", base);

    // One-pixel frame (TUSER and TLAST together) leaves rowcnt at 1, so the next line is all border.
    base = out_n;
    send(8'hFF, 1'b1, 1'b1);
    send_line(32, 8'hFF, 8'h00, 1'b0);
    drain();
    check("t2b_count", 64'(out_n - base), 64'd33);
    check("t2b_last1", {63'd0, out_last[base]}, 64'd1);
    or_all("t2b_zero", base, 33);

    // Same image with a 5-cycle output stall in the middle of line 1.
    base = out_n;
    send_line(32, 8'h00, 8'hFF, 1'b1);
    for (int c = 0; c < 32; c++) begin
      if (c == 10) stall_at = cyc + 1;
      send((c < 16) ? 8'h00 : 8'hFF, 1'b0, c == 31);
    end
    send_line(32, 8'h00, 8'hFF, 1'b0);
    send_line(32, 8'h00, 8'hFF, 1'b0);
    drain();
    check_split4("t3", base);

    // Reset in the middle of a line, then three flat lines.
    send_line(32, 8'h00, 8'hFF, 1'b1);
    send_line(32, 8'h00, 8'hFF, 1'b0);
    for (int c = 0; c < 10; c++) send(8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t4_tvalid_after_reset", {63'd0, m_tvalid}, 64'd0);
    @(posedge clk); #1;
    base = out_n;
    for (int l = 0; l < 3; l++) send_line(32, 8'hFF, 8'hFF, 1'b0);
    drain();
    check("t4_count", 64'(out_n - base), 64'd96);
    or_all("t4_zero", base, 96);
    check("t4_overflow", {63'd0, overflow}, 64'd0);

    // A 70-pixel line without TLAST overruns the 64-entry buffers.
    do_reset();
    base = out_n;
    for (int c = 0; c < 70; c++) begin
      send(8'h00, c == 0, 1'b0);
      if (c == 59) check("t5_overflow_early", {63'd0, overflow}, 64'd0);
    end
    drain();
    check("t5_overflow_set", {63'd0, overflow}, 64'd1);
    check("t5_count", 64'(out_n - base), 64'd70);
    do_reset();
    check("t5_overflow_cleared", {63'd0, overflow}, 64'd0);

`ifdef SOBEL_THRESH_EN
    thresh = 8'h80;
    base = out_n;
    for (int l = 0; l < 4; l++) send_line(32, 8'h00, 8'h20, l == 0);
    drain();
    or_all("t6_below", base, 128);
    thresh = 8'h10;
    base = out_n;
    for (int l = 0; l < 4; l++) send_line(32, 8'h00, 8'h20, l == 0);
    drain();
    check("t6_r2c16", {32'd0, out_data[base + 80]}, 64'hFFFF_FFFF);
    check("t6_r2c17", {32'd0, out_data[base + 81]}, 64'hFFFF_FFFF);
    check("t6_r2c18", {32'd0, out_data[base + 82]}, 64'd0);
    thresh = 8'h01;
`endif

    // Randomized frames: random pixels, line lengths, input gaps and output backpressure.
    rnd_rdy = 1;
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(3, LM);
      nl = $urandom_range(3, 5);
      for (int l = 0; l < nl; l++)
        for (int c = 0; c < len; c++) begin
          if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
          send(8'($urandom()), l == 0 && c == 0, c == len - 1);
        end
    end
    drain();
    rnd_rdy = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
